// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_if
// Purpose  : Bundles the requester, ALU and response signals of the shared
//            ALU arbiter. The slave modport is the arbiter's view; the master
//            modport is the view of the requesters, ALU and response consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if;
  // requester 0 (EX-stage issue port)
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  // requester 1 (auxiliary port)
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  // shared ALU operand/control and result
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  // response register
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one combinational ALU between two requesters. The granted
//            request drives the ALU in its grant cycle; the result and zero
//            flag land in a single-entry response register released by a
//            valid/ready handshake.
// Config   : ALU_ARB_RR_EN defined   -> round-robin tie-break (last_gnt kept)
//            ALU_ARB_RR_EN undefined -> fixed priority, req0 wins every tie
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
);

  logic        w_slot_free;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any_gnt;

  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_result;
  logic        r_rsp_zero;

`ifdef ALU_ARB_RR_EN
  logic        r_last_gnt;
`endif

  // The slot can take a new result when empty or being drained this cycle.
  assign w_slot_free = !r_rsp_valid || bus.rsp_ready;
  assign w_any_gnt   = w_gnt0 || w_gnt1;

  // Grant selection; forced idle while reset is asserted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n && w_slot_free) begin
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
        // grant the requester that did not win last time
        w_gnt0 = r_last_gnt;
        w_gnt1 = !r_last_gnt;
`else
        w_gnt0 = 1'b1;
`endif
      end else begin
        w_gnt0 = bus.req0_valid;
        w_gnt1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  // ALU operand/control mux: granted requester's fields, otherwise all zero.
  always_comb begin
    bus.alu_op = 4'b0000;
    bus.alu_a  = 32'd0;
    bus.alu_b  = 32'd0;
    if (w_gnt0) begin
      bus.alu_op = bus.req0_op;
      bus.alu_a  = bus.req0_a;
      bus.alu_b  = bus.req0_b;
    end else if (w_gnt1) begin
      bus.alu_op = bus.req1_op;
      bus.alu_a  = bus.req1_a;
      bus.alu_b  = bus.req1_b;
    end
  end

  // Response slot: capture on accept, clear on a drain without a new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= 32'd0;
      r_rsp_zero   <= 1'b0;
    end else if (w_any_gnt) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_gnt1;
      r_rsp_result <= bus.alu_result;
      r_rsp_zero   <= bus.alu_zero;
    end else if (r_rsp_valid && bus.rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_ARB_RR_EN
  // Round-robin pointer; reset to 1 so req0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (w_any_gnt) begin
      r_last_gnt <= w_gnt1;
    end
  end
`endif

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Arbitrates one shared ALU between two requesters: the EX-stage issue port (req0) and an auxiliary port (req1, e.g. an address/compare helper). Each accepted request drives the ALU combinationally in its grant cycle. The ALU result and zero flag are captured into a single-entry response register, released under a valid/ready handshake. The block sits between the requesters and the ALU's operand/control inputs, and owns all ALU sequencing.

## Interface
Parameters:
- None; data width fixed at 32, op width fixed at 4.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_op  in  4  ALU control code.
- req0_a  in  32  operand to ALU readdata1 side.
- req0_b  in  32  operand to ALU second-source side.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as req0, for requester 1.
- alu_op  out  4  to ALU control input.
- alu_a  out  32  to ALU first operand.
- alu_b  out  32  to ALU second operand.
- alu_result  in  32  from ALU.
- alu_zero  in  1  from ALU.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  0 = req0, 1 = req1.
- rsp_result  out  32  captured ALU result.
- rsp_zero  out  1  captured zero flag.

## Operation
- State: response slot, EMPTY or FULL, held in rsp_valid. Round-robin pointer last_gnt, 1 bit.
- Slot free this cycle: slot_free = !rsp_valid || rsp_ready.
- Grant rule when slot_free:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_gnt is granted. See Configuration for the alternative rule.
  - No slot free: no grant.
- reqN_ready = granted N. This is combinational from the valids, last_gnt and slot_free. A requester holds valid and payload stable until it sees ready. At most one ready is high per cycle.
- ALU drive:
  - Grant cycle: alu_op/alu_a/alu_b are the granted requester's fields.
  - No grant: alu_op = 4'b0000, alu_a = 0, alu_b = 0.
- Opcodes are forwarded unchecked. Codes other than 0000/0001/0010/0110/0111 yield the ALU default of 0, so rsp_zero = 1.
- On an accept edge: rsp_result ← alu_result, rsp_zero ← alu_zero, rsp_id ← granted index, rsp_valid ← 1, last_gnt ← granted index.
- On a drain edge (rsp_valid && rsp_ready) with no new grant: rsp_valid ← 0; data fields hold their last values.
- Drain and grant on the same edge: the new result replaces the old one, and rsp_valid stays 1.

## Timing
- Reset values:
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_zero = 0.
  - last_gnt = 1, so req0 wins the first tie.
  - While rst_n is low, req0_ready = req1_ready = 0 and alu_* = 0.
- Latency: request accepted at edge N → rsp_valid = 1 and data valid from edge N+1 onward.
- Throughput: 1 operation per cycle while rsp_ready is held high.
- Backpressure: if rsp_valid = 1 and rsp_ready = 0, both readies are 0. rsp_* must hold bit-stable until the handshake completes.
- Reset asserted mid-operation: rsp_valid clears asynchronously and any pending response is discarded. Requesters whose ready never went high must re-present after reset.
- reqN_ready may depend combinationally on reqN_valid. Requesters must not make valid depend on ready.

## Configuration
- ALU_ARB_RR_EN defined: round-robin tie-break as above. last_gnt updates on every accept.
- ALU_ARB_RR_EN undefined: fixed priority, req0 always wins a tie. last_gnt is not implemented, and req1 is granted only when req0_valid = 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold rst_n = 0 with both valids high → readies 0, rsp_valid 0, alu_op = 0. Release → first grant goes to req0.
- Single op: req0 op 0010, a = 5, b = 7 → req0_ready = 1 in the same cycle. Next cycle rsp_valid = 1, rsp_id = 0, rsp_result = 12, rsp_zero = 0.
- Tie, both valid for 2 cycles, rsp_ready = 1:
  - With ALU_ARB_RR_EN: grants req0 then req1; rsp_id sequence 0, 1.
  - Without ALU_ARB_RR_EN: req0 is granted both cycles.
- Backpressure: fill the slot with req1 op 0111, a = 3, b = 8 (result 1), then rsp_ready = 0 for 3 cycles → both readies 0, and rsp_result = 1, rsp_id = 1 stay stable. Set rsp_ready = 1 with req0 valid → drain and accept on the same edge.
- Zero/unsupported: op 0110, a = 9, b = 9 → result 0, zero 1. Op 1111, a = 1, b = 2 → result 0, zero 1.
- Async reset while rsp_valid = 1 and rsp_ready = 0 → rsp_valid falls without waiting for a clock edge. After release, the first request completes with normal 1-cycle latency.
